// File: rtl/sync_fifo_if.sv
// sync_fifo handshake bundle: write/read requests, read data, flags,
// occupancy and sticky error flags. master = producer/consumer, slave = FIFO.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 4
);
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_WIDTH:0]    count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output w_en, data_in, r_en, err_clr,
      input  data_out, data_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en, err_clr,
      output data_out, data_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with threshold flags, occupancy count, sticky
// overflow/underflow and selectable registered or fall-through read.
// Ports: clk, rst_n (async active-low), bus (sync_fifo_if.slave).
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 4,
   parameter int AF_THRESH  = 2**PTR_WIDTH - 2,
   parameter int AE_THRESH  = 2,
   parameter bit FWFT       = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   sync_fifo_if.slave  bus
);
   localparam int DEPTH = 2**PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] AF_T = (PTR_WIDTH+1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH:0]    wr_ptr;
   logic [PTR_WIDTH:0]    rd_ptr;
   logic [PTR_WIDTH:0]    cnt;
   logic [PTR_WIDTH-1:0]  wr_addr;
   logic [PTR_WIDTH-1:0]  rd_addr;
   logic                  empty_i;
   logic                  full_i;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ovf_q;
   logic                  udf_q;

   assign wr_addr = wr_ptr[PTR_WIDTH-1:0];
   assign rd_addr = rd_ptr[PTR_WIDTH-1:0];

   // Extra pointer MSB separates full from empty when addresses match.
   assign empty_i = (wr_ptr == rd_ptr);
   assign full_i  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH])
                 && (wr_addr == rd_addr);

   assign wr_acc = bus.w_en && !full_i;
   assign rd_acc = bus.r_en && !empty_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= bus.data_in;
   end

   // A new set event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.w_en && full_i)  ovf_q <= 1'b1;
         else if (bus.err_clr)    ovf_q <= 1'b0;
         if (bus.r_en && empty_i) udf_q <= 1'b1;
         else if (bus.err_clr)    udf_q <= 1'b0;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out   = mem[rd_addr];
         assign bus.data_valid = !empty_i;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  dv_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else begin
               dv_q <= rd_acc;
               if (rd_acc) dout_q <= mem[rd_addr];
            end
         end

         assign bus.data_out   = dout_q;
         assign bus.data_valid = dv_q;
      end
   endgenerate

   assign bus.empty        = empty_i;
   assign bus.full         = full_i;
   assign bus.count        = cnt;
   assign bus.almost_full  = (cnt >= AF_T);
   assign bus.almost_empty = (cnt <= AE_T);
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: registered-read and fall-through instances run the
// same directed stimulus against a queue model plus literal expectations.
module tb_sync_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       w_en = 1'b0;
   logic [7:0] data_in = '0;
   logic       r_en = 1'b0;
   logic       err_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   sync_fifo_if #(.DATA_WIDTH(8), .PTR_WIDTH(2)) f0 ();
   sync_fifo_if #(.DATA_WIDTH(8), .PTR_WIDTH(2)) f1 ();

   assign f0.w_en    = w_en;
   assign f0.data_in = data_in;
   assign f0.r_en    = r_en;
   assign f0.err_clr = err_clr;
   assign f1.w_en    = w_en;
   assign f1.data_in = data_in;
   assign f1.r_en    = r_en;
   assign f1.err_clr = err_clr;

   sync_fifo #(
      .DATA_WIDTH(8), .PTR_WIDTH(2), .AF_THRESH(3),
      .AE_THRESH(1), .FWFT(1'b0)
   ) dut0 (.clk(clk), .rst_n(rst_n), .bus(f0));

   sync_fifo #(
      .DATA_WIDTH(8), .PTR_WIDTH(2), .AF_THRESH(3),
      .AE_THRESH(1), .FWFT(1'b1)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(f1));

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural model: a queue of at most 4 words.
   logic [7:0] q[$];
   logic [7:0] m_dout = '0;
   bit         m_dv = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;
   int         m_n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_dout = '0;
         m_dv   = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         m_n  = q.size();
         m_dv = 1'b0;
         if (r_en && m_n > 0) begin
            m_dout = q.pop_front();
            m_dv   = 1'b1;
         end
         if (w_en && m_n < 4) q.push_back(data_in);
         if (w_en && m_n == 4) m_ovf = 1'b1;
         else if (err_clr)     m_ovf = 1'b0;
         if (r_en && m_n == 0) m_udf = 1'b1;
         else if (err_clr)     m_udf = 1'b0;
      end
   end

   int sz;
   always @(negedge clk) begin
      sz = q.size();
      chk("count0", 32'(f0.count), sz);
      chk("count1", 32'(f1.count), sz);
      chk("empty0", f0.empty, sz == 0);
      chk("empty1", f1.empty, sz == 0);
      chk("full0", f0.full, sz == 4);
      chk("full1", f1.full, sz == 4);
      chk("afull0", f0.almost_full, sz >= 3);
      chk("afull1", f1.almost_full, sz >= 3);
      chk("aempty0", f0.almost_empty, sz <= 1);
      chk("aempty1", f1.almost_empty, sz <= 1);
      chk("ovf0", f0.overflow, m_ovf);
      chk("ovf1", f1.overflow, m_ovf);
      chk("udf0", f0.underflow, m_udf);
      chk("udf1", f1.underflow, m_udf);
      chk("dvalid0", f0.data_valid, m_dv);
      chk("dout0", f0.data_out, m_dout);
      chk("dvalid1", f1.data_valid, sz != 0);
      if (sz != 0) chk("dout1", f1.data_out, q[0]);
   end

   task automatic cyc(input bit w, input logic [7:0] d,
                      input bit r, input bit c = 1'b0);
      w_en    = w;
      data_in = d;
      r_en    = r;
      err_clr = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] fill [4];
      fill = '{8'h11, 8'h22, 8'h33, 8'h44};

      @(negedge clk);
      chk("rst_count", 32'(f0.count), 0);
      chk("rst_empty", f0.empty, 1);
      chk("rst_aempty", f0.almost_empty, 1);
      chk("rst_afull", f0.almost_full, 0);
      chk("rst_dout", f0.data_out, 0);
      chk("rst_dv", f0.data_valid, 0);
      chk("rst_dv1", f1.data_valid, 0);
      rst_n = 1'b1;

      // Fill
      for (int i = 0; i < 4; i++) begin
         cyc(1, fill[i], 0);
         chk("fill_count", 32'(f0.count), i + 1);
      end
      chk("fill_full", f0.full, 1);
      chk("fill_afull", f0.almost_full, 1);
      chk("fill_aempty", f0.almost_empty, 0);

      // Overflow: 0x55 must not be stored
      cyc(1, 8'h55, 0);
      chk("ovf_set", f0.overflow, 1);
      chk("ovf_count", 32'(f0.count), 4);

      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1);
         chk("drain_dout", f0.data_out, fill[i]);
         chk("drain_dv", f0.data_valid, 1);
      end
      cyc(0, 0, 0);
      chk("idle_dv", f0.data_valid, 0);
      chk("idle_hold", f0.data_out, 8'h44);
      chk("drain_empty", f0.empty, 1);

      // Underflow and clear
      cyc(0, 0, 1);
      chk("udf_set", f0.underflow, 1);
      cyc(0, 0, 0, 1);
      chk("clr_ovf", f0.overflow, 0);
      chk("clr_udf", f0.underflow, 0);

      // Simultaneous at count 2
      cyc(1, 8'hA1, 0);
      cyc(1, 8'hA2, 0);
      cyc(1, 8'hA3, 1);
      chk("sim_dout_a", f0.data_out, 8'hA1);
      cyc(1, 8'hA4, 1);
      cyc(1, 8'hA5, 1);
      chk("sim_dout_c", f0.data_out, 8'hA3);
      chk("sim_count", 32'(f0.count), 2);

      // Simultaneous at full
      cyc(1, 8'hA6, 0);
      cyc(1, 8'hA7, 0);
      cyc(1, 8'h99, 1);
      chk("full_wr_count", 32'(f0.count), 3);
      chk("full_wr_ovf", f0.overflow, 1);
      chk("full_wr_dout", f0.data_out, 8'hA4);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("full_wr_last", f0.data_out, 8'hA7);

      // Simultaneous at empty
      cyc(1, 8'h77, 1);
      chk("empty_wr_count", 32'(f0.count), 1);
      chk("empty_wr_udf", f0.underflow, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1);
      chk("empty_wr_dout", f0.data_out, 8'h77);

      // Wrap-around
      for (int i = 0; i < 10; i++) begin
         cyc(1, 8'(8'hC0 + i), 0);
         cyc(0, 0, 1);
         chk("wrap_dout", f0.data_out, 8'hC0 + i);
      end

      // Fall-through read
      cyc(1, 8'hA5, 0);
      chk("fwft_dv", f1.data_valid, 1);
      chk("fwft_dout", f1.data_out, 8'hA5);
      cyc(1, 8'h5A, 0);
      cyc(0, 0, 1);
      chk("fwft_next", f1.data_out, 8'h5A);
      cyc(0, 0, 1);
      chk("fwft_dv_off", f1.data_valid, 0);
      chk("fwft_empty", f1.empty, 1);

      // Async reset mid-stream
      cyc(1, 8'hE1, 0);
      cyc(1, 8'hE2, 0);
      cyc(1, 8'hE3, 1);
      cyc(0, 0, 0);
      chk("pre_rst_count", 32'(f0.count), 2);
      cyc(1, 8'hE4, 0);
      chk("pre_rst_count3", 32'(f0.count), 3);
      w_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(f0.count), 0);
      chk("arst_empty", f0.empty, 1);
      chk("arst_dout", f0.data_out, 0);
      chk("arst_aempty", f0.almost_empty, 1);
      chk("arst_dv1", f1.data_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 8'hC3, 0);
      cyc(0, 0, 1);
      chk("post_rst_dout", f0.data_out, 8'hC3);
      cyc(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO. Pointer, flag and occupancy logic are integrated with the storage array, so no external pointer or flag inputs are needed. Adds threshold flags, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Intended as the general-purpose buffer for single-domain datapaths and the reference model for the FIFO verification environment.

Parameters:
DATA_WIDTH, 8, width of each stored word
PTR_WIDTH, 4, address width; DEPTH = 2**PTR_WIDTH (derived, not overridable)
AF_THRESH, 2**PTR_WIDTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request (FWFT=1: pop/acknowledge of head word)
data_out  output  DATA_WIDTH  read data
data_valid  output  1  data_out holds a valid word
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, asynchronous): write/read pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0, data_valid 0. Storage array is not reset. Reset asserted mid-operation discards all contents immediately.
- Pointers are PTR_WIDTH+1-bit binary. Address = low PTR_WIDTH bits. Pointers wrap naturally modulo 2*DEPTH.
- empty = pointers equal. full = MSBs differ and low bits equal. Both flags derive from registered pointers and are glitch-free.
- Write accepted iff w_en && !full. Read accepted iff r_en && !empty. Acceptance is evaluated on pre-edge flags.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- Full with w_en && r_en: only the read is accepted; count decrements; overflow is set.
- Empty with w_en && r_en: only the write is accepted; count increments; underflow is set.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- almost_full and almost_empty are compared from the registered count, so they change in the same cycle as count.
- overflow sets on (w_en && full); underflow sets on (r_en && empty). Both hold until err_clr. If a set condition and err_clr occur in the same cycle, set wins. Rejected operations never alter pointers, count or storage.
- FWFT=0: on an accepted read, data_out <= mem[rd_addr] at the same edge and data_valid = 1 for exactly one cycle. data_out otherwise holds its last value and data_valid = 0. Read latency is 1 cycle from r_en.
- FWFT=1: data_out = mem[rd_addr] continuously and data_valid = !empty. A word written at edge N is visible on data_out after edge N when the FIFO was empty. An accepted r_en advances to the next word after the edge. data_out is don't-care while data_valid = 0.
- Write-to-empty-deassert latency is 1 edge in both modes.

Test Plan:
(Parameters for all scenarios: DATA_WIDTH=8, PTR_WIDTH=2 so DEPTH=4, AF_THRESH=3, AE_THRESH=1.)
- Reset and fill, FWFT=0: reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count steps 1..4; almost_empty drops when count reaches 2; almost_full rises when count reaches 3; full=1 after the 4th write. Then read 4 times -> data_out = 0x11, 0x22, 0x33, 0x44, each one cycle after its r_en with data_valid pulsing; empty=1 at the end.
- Overflow and underflow: with the FIFO full, write 0x55 -> overflow=1, count stays 4, and the next reads return 0x11.. (0x55 was never stored). Drain, then r_en while empty -> underflow=1. Assert err_clr for one cycle -> both flags 0.
- Simultaneous operations: at count=2, w_en && r_en for 3 cycles -> count stays 2 and data order is preserved. At full, w_en && r_en -> count becomes 3 and overflow=1. At empty, w_en && r_en -> count becomes 1 and underflow=1.
- Wrap-around: perform 10 write/read pairs through DEPTH=4 -> the pointers wrap at least twice and every word reads back in order with no false full or empty.
- FWFT=1: write 0xA5 into an empty FIFO -> after the edge, data_valid=1 and data_out=0xA5 without any r_en. Write 0x5A, then pulse r_en -> data_out becomes 0x5A. A second r_en -> data_valid=0 and empty=1.
- Asynchronous reset mid-stream: assert rst_n low between clock edges at count=3 -> all outputs return to their reset values immediately, without waiting for a clock edge. After release, the first read returns newly written data only.
